// File: rtl/aes_link_pkg.sv
// Shared command/reply codes and controller state encoding for the AES link controller.
package aes_link_pkg;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_PT  = 8'h50;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StStart,
    StWait,
    StSend,
    StTxWait,
    StReply
  } link_state_e;

endpackage

// File: rtl/byte_shift128.sv
// 128-bit register with parallel load and shift-left-by-8; [127:120] is the outgoing byte.
module byte_shift128 (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [127:0] i_load_data,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [127:0] o_data
);

  logic [127:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {r_data[119:0], i_byte};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/aes_link_ctrl.sv
// Host frame parser and sequencer: assembles key/plaintext from UART bytes, runs one
// AES-128 encryption per 'P' frame and streams the ciphertext back, bracketing it with a trigger.
module aes_link_ctrl
  import aes_link_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 200000,
  parameter int unsigned AES_TIMEOUT = 4096
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_start,
  input  logic         i_tx_done,
  output logic [127:0] o_aes_key,
  output logic [127:0] o_aes_pt,
  output logic         o_aes_start,
  input  logic         i_aes_done,
  input  logic [127:0] i_aes_ct,
  output logic         o_trigger,
  output logic         o_busy,
  output logic         o_err
);

  localparam int unsigned GapW = $clog2(GAP_TIMEOUT + 1);
  localparam int unsigned AesW = $clog2(AES_TIMEOUT + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_TIMEOUT - 1);
  localparam logic [AesW-1:0] AesLast = AesW'(AES_TIMEOUT - 1);

  link_state_e     r_state;
  logic [7:0]      r_cmd;
  logic [3:0]      r_cnt;
  logic [GapW-1:0] r_gap_cnt;
  logic [AesW-1:0] r_aes_cnt;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic [127:0]    r_key;
  logic [127:0]    r_pt;
  logic            r_aes_start;
  logic            r_trigger;
  logic            r_busy;
  logic            r_err;

  logic            w_sh_load;
  logic            w_sh_shift;
  logic [7:0]      w_sh_in;
  logic [127:0]    w_sh_data;
  logic [127:0]    w_frame;
  logic            w_rx_drop;

  // The 16th byte is still on i_rx_data when the frame completes.
  assign w_frame   = {w_sh_data[119:0], i_rx_data};
  assign w_rx_drop = i_rx_valid &
                     (r_state inside {StStart, StWait, StSend, StTxWait, StReply});

  // Shared shifter: rx assembly in RECV, ciphertext serializer in WAIT/TXWAIT.
  always_comb begin
    w_sh_load  = 1'b0;
    w_sh_shift = 1'b0;
    w_sh_in    = i_rx_data;
    case (r_state)
      StRecv:   w_sh_shift = i_rx_valid;
      StWait:   w_sh_load  = i_aes_done;
      StTxWait: begin
        w_sh_shift = i_tx_done;
        w_sh_in    = 8'h00;
      end
      default: ;
    endcase
  end

  byte_shift128 u_shift (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_sh_load),
    .i_load_data ({i_aes_ct[119:0], 8'h00}),
    .i_shift     (w_sh_shift),
    .i_byte      (w_sh_in),
    .o_data      (w_sh_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_aes_cnt   <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_key       <= '0;
      r_pt        <= '0;
      r_aes_start <= 1'b0;
      r_trigger   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_aes_start <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_rx_valid) begin
            r_busy <= 1'b1;
            if (i_rx_data == CMD_KEY || i_rx_data == CMD_PT) begin
              r_cmd     <= i_rx_data;
              r_cnt     <= '0;
              r_gap_cnt <= '0;
              r_err     <= 1'b0;
              r_state   <= StRecv;
            end else begin
              r_err      <= 1'b1;
              r_tx_data  <= RSP_BAD;
              r_tx_start <= 1'b1;
              r_state    <= StReply;
            end
          end
        end
        StRecv: begin
          if (i_rx_valid) begin
            r_gap_cnt <= '0;
            r_cnt     <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              if (r_cmd == CMD_KEY) begin
                r_key      <= w_frame;
                r_tx_data  <= RSP_ACK;
                r_tx_start <= 1'b1;
                r_state    <= StReply;
              end else begin
                r_pt        <= w_frame;
                r_aes_start <= 1'b1;
                r_trigger   <= 1'b1;
                r_aes_cnt   <= '0;
                r_state     <= StStart;
              end
            end
          end else if (r_gap_cnt >= GapLast) begin
            // Silent abort: partial payload never reaches key/pt.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt + GapW'(1);
          end
        end
        StStart: begin
          r_aes_cnt <= r_aes_cnt + AesW'(1);
          r_state   <= StWait;
        end
        StWait: begin
          if (i_aes_done) begin
            r_trigger  <= 1'b0;
            r_tx_data  <= i_aes_ct[127:120];
            r_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= StSend;
          end else if (r_aes_cnt >= AesLast) begin
            r_trigger  <= 1'b0;
            r_tx_data  <= RSP_NAK;
            r_tx_start <= 1'b1;
            r_err      <= 1'b1;
            r_state    <= StReply;
          end else begin
            r_aes_cnt <= r_aes_cnt + AesW'(1);
          end
        end
        StSend: r_state <= StTxWait;
        StTxWait: begin
          if (i_tx_done) begin
            if (r_cnt == 4'd15) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_cnt      <= r_cnt + 4'd1;
              r_tx_data  <= w_sh_data[127:120];
              r_tx_start <= 1'b1;
              r_state    <= StSend;
            end
          end
        end
        StReply: begin
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_rx_drop) r_err <= 1'b1;
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_aes_key   = r_key;
  assign o_aes_pt    = r_pt;
  assign o_aes_start = r_aes_start;
  assign o_trigger   = r_trigger;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_aes_link_ctrl.sv
// Self-checking bench for aes_link_ctrl: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_aes_link_ctrl;

  localparam int unsigned GapT = 64;
  localparam int unsigned AesT = 100;
  localparam int TxLat = 3;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [7:0]   i_rx_data;
  logic         i_rx_valid;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic         i_tx_done;
  logic [127:0] o_aes_key;
  logic [127:0] o_aes_pt;
  logic         o_aes_start;
  logic         i_aes_done;
  logic [127:0] i_aes_ct;
  logic         o_trigger;
  logic         o_busy;
  logic         o_err;

  always #5 clk = ~clk;

  aes_link_ctrl #(
    .GAP_TIMEOUT (GapT),
    .AES_TIMEOUT (AesT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_aes_key   (o_aes_key),
    .o_aes_pt    (o_aes_pt),
    .o_aes_start (o_aes_start),
    .i_aes_done  (i_aes_done),
    .i_aes_ct    (i_aes_ct),
    .o_trigger   (o_trigger),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor (sole writer of these)
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         trig_cnt = 0;
  int         fall_cyc = 0;
  bit         prev_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        tx_q.push_back(o_tx_data);
        tx_cyc_q.push_back(cyc);
      end
      if (o_aes_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (o_trigger) trig_cnt++;
      if (prev_busy && !o_busy) fall_cyc = cyc;
      prev_busy = o_busy;
    end
  end

  // UART transmitter and AES core models
  bit           aes_en = 1'b1;
  int           aes_lat = 20;
  logic [127:0] aes_ct_val = {4{32'hdeadbeef}};
  int           done_cnt = 0;
  int           last_done_cyc = 0;

  initial begin
    int tx_tmr;
    int aes_tmr;
    tx_tmr = 0;
    aes_tmr = 0;
    i_tx_done = 1'b0;
    i_aes_done = 1'b0;
    i_aes_ct = '0;
    forever begin
      @(posedge clk);
      #2;
      i_tx_done = 1'b0;
      i_aes_done = 1'b0;
      i_aes_ct = '0;
      if (i_reset) begin
        tx_tmr = 0;
        aes_tmr = 0;
      end else begin
        if (tx_tmr > 0) begin
          tx_tmr--;
          if (tx_tmr == 0) begin
            i_tx_done = 1'b1;
            done_cnt++;
            last_done_cyc = cyc;
          end
        end
        if (o_tx_start) tx_tmr = TxLat;
        if (aes_tmr > 0) begin
          aes_tmr--;
          if (aes_tmr == 0) begin
            i_aes_done = 1'b1;
            i_aes_ct = aes_ct_val;
          end
        end
        if (o_aes_start && aes_en) aes_tmr = aes_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int at);
    i_rx_valid = 1'b1;
    i_rx_data = b;
    at = cyc;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] pl, input int max_gap,
                            output int n_last);
    send_byte(cmd, $urandom_range(0, max_gap), n_last);
    if (cmd == 8'h4B || cmd == 8'h50) begin
      for (int i = 0; i < 16; i++)
        send_byte(pl[127-8*i -: 8], (i == 15) ? 0 : $urandom_range(0, max_gap), n_last);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      tick();
      n++;
    end
    chk_i({nm, "/idle"}, int'(o_busy), 0);
    repeat (2) tick();
  endtask

  task automatic check_zero(input string tag);
    chk_i({tag, "/tx_data"}, int'(o_tx_data), 0);
    chk_i({tag, "/tx_start"}, int'(o_tx_start), 0);
    chk({tag, "/key"}, o_aes_key, '0);
    chk({tag, "/pt"}, o_aes_pt, '0);
    chk_i({tag, "/aes_start"}, int'(o_aes_start), 0);
    chk_i({tag, "/trigger"}, int'(o_trigger), 0);
    chk_i({tag, "/busy"}, int'(o_busy), 0);
    chk_i({tag, "/err"}, int'(o_err), 0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] cmd, input int bt, input int bs,
                             input int br, input int n_last, input int n_tx,
                             input logic [127:0] exp_tx, input logic exp_err,
                             input logic [127:0] exp_key, input logic [127:0] exp_pt,
                             input int lat);
    logic [127:0] got;
    bit is_p;
    got = '0;
    is_p = (cmd == 8'h50);
    chk_i({tag, "/ntx"}, tx_q.size() - bt, n_tx);
    for (int i = 0; i < n_tx; i++)
      if (bt + i < tx_q.size()) got[127-8*i -: 8] = tx_q[bt+i];
    chk({tag, "/tx_bytes"}, got, exp_tx);
    chk({tag, "/key"}, o_aes_key, exp_key);
    chk({tag, "/pt"}, o_aes_pt, exp_pt);
    chk_i({tag, "/err"}, int'(o_err), int'(exp_err));
    chk_i({tag, "/starts"}, start_cnt - bs, is_p ? 1 : 0);
    chk_i({tag, "/trig_cycles"}, trig_cnt - br, is_p ? lat + 1 : 0);
    if (cmd == 8'h4B && tx_q.size() > bt) chk_i({tag, "/ack_cyc"}, tx_cyc_q[bt], n_last + 1);
    if (is_p) begin
      chk_i({tag, "/start_cyc"}, start_cyc, n_last + 1);
      if (tx_q.size() > bt) chk_i({tag, "/ct0_cyc"}, tx_cyc_q[bt], start_cyc + lat + 1);
      chk_i({tag, "/busy_fall"}, fall_cyc, last_done_cyc + 1);
    end
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] pl;
    int           n_tx;
    logic [127:0] tx;
    logic         err;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] P5 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] Ct = {4{32'hdeadbeef}};

  initial begin
    vec_t vt[6];
    logic [127:0] m_key;
    logic [127:0] m_pt;
    int bt, bs, br, nl, dummy, n;

    vt[0] = '{8'h4B, K0, 1, {8'h06, 120'h0}, 1'b0, K0, '0};
    vt[1] = '{8'h50, P1, 16, Ct, 1'b0, K0, P1};
    vt[2] = '{8'h41, '0, 1, {8'h3F, 120'h0}, 1'b1, K0, P1};
    vt[3] = '{8'h4B, K3, 1, {8'h06, 120'h0}, 1'b0, K3, P1};
    vt[4] = '{8'h00, '0, 1, {8'h3F, 120'h0}, 1'b1, K3, P1};
    vt[5] = '{8'h50, P5, 16, Ct, 1'b0, K3, P5};

    i_reset = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check_zero("reset");

    for (int v = 0; v < 6; v++) begin
      bt = tx_q.size();
      bs = start_cnt;
      br = trig_cnt;
      send_frame(vt[v].cmd, vt[v].pl, 1, nl);
      wait_idle($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), vt[v].cmd, bt, bs, br, nl, vt[v].n_tx, vt[v].tx,
                  vt[v].err, vt[v].key, vt[v].pt, 20);
    end

    // A gap of exactly GapT cycles between bytes is still accepted.
    bt = tx_q.size();
    bs = start_cnt;
    br = trig_cnt;
    send_byte(8'h4B, 0, nl);
    for (int i = 0; i < 16; i++) send_byte(P1[127-8*i -: 8], (i == 5) ? GapT - 1 : 0, nl);
    wait_idle("gap_edge");
    check_frame("gap_edge", 8'h4B, bt, bs, br, nl, 1, {8'h06, 120'h0}, 1'b0, P1, P5, 0);

    // Gap timeout aborts silently.
    bt = tx_q.size();
    bs = start_cnt;
    send_byte(8'h50, 0, nl);
    for (int i = 0; i < 5; i++) send_byte(8'(i), 0, nl);
    repeat (GapT - 1) tick();
    chk_i("gap/busy_before", int'(o_busy), 1);
    tick();
    chk_i("gap/busy_after", int'(o_busy), 0);
    chk_i("gap/err", int'(o_err), 1);
    repeat (5) tick();
    chk_i("gap/ntx", tx_q.size() - bt, 0);
    chk_i("gap/starts", start_cnt - bs, 0);
    chk("gap/pt", o_aes_pt, P5);
    bt = tx_q.size();
    bs = start_cnt;
    br = trig_cnt;
    send_frame(8'h4B, K3, 0, nl);
    wait_idle("gap_rec");
    check_frame("gap_rec", 8'h4B, bt, bs, br, nl, 1, {8'h06, 120'h0}, 1'b0, K3, P5, 0);

    // AES timeout with a stray rx byte during WAIT.
    aes_en = 1'b0;
    bt = tx_q.size();
    bs = start_cnt;
    br = trig_cnt;
    send_frame(8'h50, K0, 0, nl);
    repeat (10) tick();
    send_byte(8'h55, 0, dummy);
    tick();
    chk_i("aes_to/err_stray", int'(o_err), 1);
    chk_i("aes_to/trigger", int'(o_trigger), 1);
    wait_idle("aes_to");
    chk_i("aes_to/ntx", tx_q.size() - bt, 1);
    if (tx_q.size() > bt) begin
      chk_i("aes_to/nak", int'(tx_q[bt]), 8'h15);
      chk_i("aes_to/nak_cyc", tx_cyc_q[bt], start_cyc + int'(AesT));
    end
    chk_i("aes_to/start_cyc", start_cyc, nl + 1);
    chk_i("aes_to/trig_cycles", trig_cnt - br, int'(AesT));
    chk_i("aes_to/err", int'(o_err), 1);
    chk("aes_to/pt", o_aes_pt, K0);
    aes_en = 1'b1;

    // Reset during ciphertext streaming after 7 bytes completed.
    aes_lat = 5;
    aes_ct_val = {$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h50, P1, 0, nl);
    n = done_cnt + 7;
    dummy = 0;
    while (done_cnt < n && dummy < 2000) begin
      tick();
      dummy++;
    end
    chk_i("rst_send/reached", int'(done_cnt >= n), 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_zero("rst_send");
    bt = tx_q.size();
    repeat (40) tick();
    chk_i("rst_send/no_tx", tx_q.size() - bt, 0);
    chk_i("rst_send/busy", int'(o_busy), 0);

    // Randomized frames against the frame-level model.
    m_key = '0;
    m_pt = '0;
    for (int r = 0; r < 24; r++) begin
      logic [7:0]   c;
      logic [127:0] pl, etx;
      logic         eerr;
      int           kind, ntx;
      kind = $urandom_range(0, 9);
      pl = {$urandom, $urandom, $urandom, $urandom};
      aes_lat = $urandom_range(1, 30);
      aes_ct_val = {$urandom, $urandom, $urandom, $urandom};
      if (kind < 4) begin
        c = 8'h4B;
        m_key = pl;
        etx = {8'h06, 120'h0};
        ntx = 1;
        eerr = 1'b0;
      end else if (kind < 8) begin
        c = 8'h50;
        m_pt = pl;
        etx = aes_ct_val;
        ntx = 16;
        eerr = 1'b0;
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h4B || c == 8'h50) c = 8'h00;
        etx = {8'h3F, 120'h0};
        ntx = 1;
        eerr = 1'b1;
      end
      bt = tx_q.size();
      bs = start_cnt;
      br = trig_cnt;
      send_frame(c, pl, 3, nl);
      wait_idle($sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r), c, bt, bs, br, nl, ntx, etx, eerr, m_key, m_pt,
                  aes_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_link_ctrl.md
# aes_link_ctrl

Framing and sequencing controller between the UART byte link and the AES-128 core. It parses host command frames, assembles keys and plaintext, launches one encryption per frame and streams the 16 ciphertext bytes back. It also drives a scope trigger that brackets the AES computation for side-channel capture.

## Interface
- GAP_TIMEOUT, 200000: max clk cycles allowed between bytes inside a frame before the frame is aborted.
- AES_TIMEOUT, 4096: max clk cycles from aes_start to aes_done before the operation is aborted.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe from the UART receiver.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle strobe to the UART transmitter.
- tx_done  in  1  one-cycle strobe; the transmitter has finished the current byte.
- aes_key  out  128  key register.
- aes_pt  out  128  plaintext register.
- aes_start  out  1  one-cycle strobe launching the AES core.
- aes_done  in  1  one-cycle strobe; aes_ct is valid in that same cycle.
- aes_ct  in  128  ciphertext.
- trigger  out  1  high while an encryption is in flight.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag.

## Operation
- Frames:
  - 'K' (0x4B) + 16 bytes: load aes_key, reply 0x06 (ACK).
  - 'P' (0x50) + 16 bytes: load aes_pt, encrypt, reply with 16 ciphertext bytes.
  - Any other command byte: reply 0x3F and set err.
- Byte order: the first payload byte goes to [127:120] and the last to [7:0]. Ciphertext is sent starting with [127:120].
- States and transitions:
  - IDLE: on a command byte, go to RECV; on an unknown byte, go to REPLY.
  - RECV: collect 16 payload bytes. After the 16th byte, 'K' goes to REPLY and 'P' goes to START.
  - START: go to WAIT.
  - WAIT: on aes_done, go to SEND; on AES timeout, go to REPLY(0x15).
  - SEND: go to TXWAIT.
  - TXWAIT: on tx_done, return to SEND, or to IDLE after byte 16.
  - REPLY: send one status byte, then go to IDLE after its tx_done.
- Payload byte counter: 4 bits, 0..15. Wrap from 15 to 0 marks frame completion.
- Payload register: 128-bit shift-left-by-8. It is committed to aes_key or aes_pt only when the frame completes, so a partial frame never alters either register.
- Inter-byte gap timeout in RECV: discard the frame, set err, return to IDLE, send no reply.
- An rx_valid arriving in START, WAIT, SEND, TXWAIT or REPLY: the byte is dropped and err is set.
- err is cleared by reset, or by acceptance of a valid command byte in IDLE.
- Reset at any point returns to IDLE. Outputs reset to:
  - tx_data, aes_key, aes_pt: 0.
  - tx_start, aes_start, trigger, busy, err: 0.
  - Any in-flight UART or AES transfer is abandoned.

## Timing
- Let the 16th payload rx_valid be in cycle n. For 'P', aes_pt is updated and aes_start and trigger rise in cycle n+1. For 'K', aes_key is updated and tx_start(0x06) fires in cycle n+1.
- aes_done in cycle m: aes_ct is latched at m. trigger falls at m+1, and tx_start with tx_data=ct[127:120] fires at m+1.
- tx_done in cycle k: the next tx_start fires at k+1. After the 16th tx_done, state is IDLE and busy is low at k+1.
- AES timeout: trigger falls at start+AES_TIMEOUT, and tx_start(0x15) fires in the same cycle.
- Simultaneous events:
  - rx_valid and gap timeout in the same cycle: the byte is accepted and the counter reloads.
  - aes_done and AES timeout in the same cycle: done wins.
- aes_start is exactly one cycle wide. Both timeout counters saturate and do not wrap.

## Structure
- Shared package aes_link_pkg holds:
  - Command codes: CMD_KEY=0x4B, CMD_PT=0x50.
  - Reply codes: RSP_ACK=0x06, RSP_NAK=0x15, RSP_BAD=0x3F.
  - The state enum.
- One sub-module, byte_shift128: a 128-bit load/shift-by-8 register. It is used for rx assembly and as the tx ciphertext serializer, with [127:120] as the output byte.

## Test plan
- Key frame: 'K', 00..0F → aes_key=0x000102…0F; exactly one tx byte 0x06; aes_start never pulses.
- Encrypt frame: 'P', 00 11 … FF; model aes_done 20 cycles after start with ct=0xdeadbeef×4 → aes_pt=0x0011…FF; trigger high for exactly 21 cycles; tx bytes DE AD BE EF ×4 in order.
- Unknown command: 0x41 → single tx byte 0x3F; err=1. A following valid 'K' frame clears err.
- Gap timeout: 'P' plus 5 bytes, then silence for GAP_TIMEOUT → err=1; aes_pt unchanged; no tx. A full frame afterwards works normally.
- AES timeout: withhold aes_done → 0x15 sent at start+AES_TIMEOUT; trigger falls; err=1. An rx byte injected during WAIT also sets err.
- Reset mid-SEND after 7 ct bytes → all outputs return to 0 the next cycle; no further tx_start.
